// File: rtl/sub_64_seq.sv
// Multi-cycle 64-bit subtractor (A - B) with ZF/SF/OF and borrow flags, CHUNK bits per clock.
// Latency: N+1 edges from the accepting edge to the done pulse (N = 64/CHUNK).
// Backpressure: start is taken only while busy==0; start during a run is ignored.
module sub_64_seq #(
  parameter int CHUNK = 8  // must divide 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic        busy,
  output logic        done,
  output logic [63:0] diff,
  output logic        overflow,
  output logic        zf,
  output logic        sf,
  output logic        borrow
);

  localparam int N  = 64 / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic [63:0]     a_reg;
  logic [63:0]     b_reg;

  logic            accept;
  logic            last;
  logic [5:0]      lsb;
  logic [CHUNK-1:0] a_chk;
  logic [CHUNK-1:0] b_chk;
  logic [CHUNK:0]  sum;
  logic [63:0]     diff_nx;

  assign accept = start && (state != S_RUN);
  assign last   = (cnt == CW'(N - 1));
  assign lsb    = 6'(int'(cnt) * CHUNK);

  // Chunk adder: A + ~B + carry on the current chunk, and the diff as it will
  // look after this edge so the flags see the final top chunk on the same edge.
  always_comb begin
    a_chk   = a_reg[lsb +: CHUNK];
    b_chk   = ~b_reg[lsb +: CHUNK];
    sum     = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, carry};
    diff_nx = diff;
    diff_nx[lsb +: CHUNK] = sum[CHUNK-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs; DONE may re-accept directly into RUN.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = start ? S_RUN : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then one chunk per RUN edge; flags on the last chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      diff     <= '0;
      overflow <= 1'b0;
      zf       <= 1'b0;
      sf       <= 1'b0;
      borrow   <= 1'b0;
    end else if (accept) begin
      a_reg    <= A;
      b_reg    <= B;
      cnt      <= '0;
      carry    <= 1'b1;
      diff     <= '0;
      overflow <= 1'b0;
      zf       <= 1'b0;
      sf       <= 1'b0;
      borrow   <= 1'b0;
    end else if (state == S_RUN) begin
      diff  <= diff_nx;
      carry <= sum[CHUNK];
      cnt   <= last ? '0 : cnt + 1'b1;
      if (last) begin
        borrow   <= ~sum[CHUNK];
        sf       <= diff_nx[63];
        zf       <= (diff_nx == 64'd0);
        overflow <= (a_reg[63] ^ b_reg[63]) & (a_reg[63] ^ diff_nx[63]);
      end
    end
  end

endmodule

// File: tb/tb_sub_64_seq.sv
// Bench for sub_64_seq: three instances (CHUNK = 8, 1, 64) driven from shared tasks.
// Latency: checked per operation against 64/CHUNK + 1 edges.
// Backpressure: start pulses during a run and held-start back-to-back are exercised.
module tb_sub_64_seq;

  logic        clk;
  logic        rst;
  logic        start_v  [3];
  logic [63:0] a_v      [3];
  logic [63:0] b_v      [3];
  logic        busy_v   [3];
  logic        done_v   [3];
  logic [63:0] diff_v   [3];
  logic        ovf_v    [3];
  logic        zf_v     [3];
  logic        sf_v     [3];
  logic        borrow_v [3];

  int total;
  int passed;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sub_64_seq #(.CHUNK((g == 0) ? 8 : (g == 1) ? 1 : 64)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .A        (a_v[g]),
      .B        (b_v[g]),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .diff     (diff_v[g]),
      .overflow (ovf_v[g]),
      .zf       (zf_v[g]),
      .sf       (sf_v[g]),
      .borrow   (borrow_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] d;
    logic        zf;
    logic        sf;
    logic        of;
    logic        bw;
  } vec_t;

  vec_t vecs [10];

  function automatic int n_of(int u);
    return (u == 0) ? 8 : (u == 1) ? 64 : 1;
  endfunction

  task automatic chk(string nm, int u, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s (unit %0d): got %h, expected %h", nm, u, act, exp);
  endtask

  task automatic chk_result(string nm, int u, vec_t v);
    chk({nm, " diff"}, u, diff_v[u], v.d);
    chk({nm, " flags{zf,sf,of,bw}"}, u,
        64'({zf_v[u], sf_v[u], ovf_v[u], borrow_v[u]}),
        64'({v.zf, v.sf, v.of, v.bw}));
  endtask

  // One full operation; optionally pokes start with other operands during the run.
  task automatic run_op(int u, vec_t v, bit intrude);
    int  edges;
    bit  got;
    @(negedge clk);
    a_v[u]     = v.a;
    b_v[u]     = v.b;
    start_v[u] = 1'b1;
    edges = 0;
    got   = 1'b0;
    while (edges < 200 && !got) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) begin
        chk("busy after accept", u, 64'(busy_v[u]), 64'd1);
        chk("result cleared on accept", u, diff_v[u], 64'd0);
        a_v[u] = intrude ? 64'd9 : {$urandom, $urandom};
        b_v[u] = intrude ? 64'd1 : {$urandom, $urandom};
      end
      start_v[u] = intrude && (edges == 1);
      if (done_v[u]) got = 1'b1;
    end
    chk("latency edges", u, 64'(edges), 64'(n_of(u) + 1));
    chk("busy low at done", u, 64'(busy_v[u]), 64'd0);
    chk_result("result", u, v);
    @(posedge clk);
    #1;
    chk("done one cycle", u, 64'(done_v[u]), 64'd0);
    chk_result("result holds", u, v);
  endtask

  task automatic reset_all();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic reset_mid_run(int u, vec_t v);
    bit seen;
    int extra;
    @(negedge clk);
    a_v[u]     = v.a;
    b_v[u]     = v.b;
    start_v[u] = 1'b1;
    @(posedge clk);
    #1;
    start_v[u] = 1'b0;
    extra = (n_of(u) >= 4) ? 3 : 0;
    repeat (extra) @(posedge clk);
    #1;
    chk("busy before mid-run reset", u, 64'(busy_v[u]), 64'd1);
    rst = 1'b1;
    #1;
    chk("reset diff", u, diff_v[u], 64'd0);
    chk("reset ctl/flags", u,
        64'({busy_v[u], done_v[u], ovf_v[u], zf_v[u], sf_v[u], borrow_v[u]}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (n_of(u) + 3) begin
      @(posedge clk);
      #1;
      if (done_v[u] || busy_v[u]) seen = 1'b1;
    end
    chk("no activity after reset", u, 64'(seen), 64'd0);
  endtask

  // start held high across DONE: the second op is accepted with no dead cycle.
  task automatic back_to_back(int u, vec_t v1, vec_t v2);
    int edges;
    bit got;
    @(negedge clk);
    a_v[u]     = v1.a;
    b_v[u]     = v1.b;
    start_v[u] = 1'b1;
    @(posedge clk);
    #1;
    a_v[u] = v2.a;
    b_v[u] = v2.b;
    edges = 1;
    got   = 1'b0;
    while (edges < 200 && !got) begin
      @(posedge clk);
      edges++;
      #1;
      if (done_v[u]) got = 1'b1;
    end
    chk("b2b first latency", u, 64'(edges), 64'(n_of(u) + 1));
    chk_result("b2b first", u, v1);
    @(posedge clk);
    #1;
    start_v[u] = 1'b0;
    chk("b2b no dead cycle", u, 64'({busy_v[u], done_v[u]}), 64'b10);
    chk("b2b cleared", u, diff_v[u], 64'd0);
    edges = 1;
    got   = 1'b0;
    while (edges < 200 && !got) begin
      @(posedge clk);
      edges++;
      #1;
      if (done_v[u]) got = 1'b1;
    end
    chk("b2b second latency", u, 64'(edges), 64'(n_of(u) + 1));
    chk_result("b2b second", u, v2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      a_v[i]     = '0;
      b_v[i]     = '0;
    end

    //            a                       b                       diff                    zf    sf    of    bw
    vecs[0] = '{64'd5,                  64'd3,                  64'd2,                  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'd0,                  64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'd1,                  64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0,                  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{64'd10,                 64'd4,                  64'd6,                  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{64'd1,                  64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{64'h0000_0001_0000_0000, 64'd1,                  64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{64'd0,                  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1};

    #2;
    for (int u = 0; u < 3; u++) begin
      chk("reset diff", u, diff_v[u], 64'd0);
      chk("reset ctl/flags", u,
          64'({busy_v[u], done_v[u], ovf_v[u], zf_v[u], sf_v[u], borrow_v[u]}), 64'd0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 10; i++) run_op(u, vecs[i], 1'b0);
      run_op(u, vecs[4], 1'b1);
      reset_mid_run(u, vecs[1]);
      run_op(u, vecs[2], 1'b0);
      back_to_back(u, vecs[5], vecs[6]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
